// File: rtl/apb_fanout_slice_pkg.sv
// Shared definitions for the APB fan-out bridge: FSM encoding and width helpers.
package apb_fanout_slice_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } apb_state_e;

  function automatic int clog2(input int value);
    int result;
    int v;
    result = 0;
    v = value - 1;
    while (v > 0) begin
      result++;
      v = v >> 1;
    end
    return result;
  endfunction

  // Port-select field width; a single port still needs one select bit.
  function automatic int sel_width(input int ns);
    return (clog2(ns) < 1) ? 1 : clog2(ns);
  endfunction

endpackage

// File: rtl/apb_port_decode.sv
// Combinational port decode: range check of the select field and the
// per-port mux of downstream read data, ready and error.
module apb_port_decode
  import apb_fanout_slice_pkg::*;
#(
  parameter int DW = 16,
  parameter int NS = 4,
  parameter int SW = sel_width(NS)
) (
  input  logic [SW-1:0]    sel_field,
  output logic             in_range,
  input  logic [SW-1:0]    port_idx,
  input  logic [NS*DW-1:0] prdata_all,
  input  logic [NS-1:0]    pready_all,
  input  logic [NS-1:0]    pslverr_all,
  output logic [DW-1:0]    prdata,
  output logic             pready,
  output logic             pslverr
);

  assign in_range = ({1'b0, sel_field} < (SW+1)'(NS));

  // Explicit compare loop keeps non-power-of-two NS free of out-of-range slices.
  always_comb begin
    prdata  = '0;
    pready  = 1'b0;
    pslverr = 1'b0;
    for (int i = 0; i < NS; i++) begin
      if (port_idx == SW'(i)) begin
        prdata  = prdata_all[i*DW +: DW];
        pready  = pready_all[i];
        pslverr = pslverr_all[i];
      end
    end
  end

endmodule

// File: rtl/apb_fanout_slice.sv
// APB bridge: registers one upstream transfer and forwards it to one of NS
// downstream ports, with decode-error responses and an ACCESS-phase watchdog.
module apb_fanout_slice
  import apb_fanout_slice_pkg::*;
#(
  parameter int DW      = 16,
  parameter int AW      = 16,
  parameter int NS      = 4,
  parameter int SEL_LSB = 12,
  parameter int TIMEOUT = 255
) (
  input  logic             APB_CLK,
  input  logic             APB_RESET,
  input  logic             APBS_PSEL,
  input  logic             APBS_PENABLE,
  input  logic             APBS_PWRITE,
  input  logic [AW-1:0]    APBS_PADDR,
  input  logic [DW-1:0]    APBS_PWDATA,
  output logic [DW-1:0]    APBS_PRDATA,
  output logic             APBS_PREADY,
  output logic             APBS_PSLVERR,
  output logic [NS-1:0]    APBM_PSEL,
  output logic             APBM_PENABLE,
  output logic             APBM_PWRITE,
  output logic [AW-1:0]    APBM_PADDR,
  output logic [DW-1:0]    APBM_PWDATA,
  input  logic [NS*DW-1:0] APBM_PRDATA,
  input  logic [NS-1:0]    APBM_PREADY,
  input  logic [NS-1:0]    APBM_PSLVERR,
  output logic             APB_TOUT,
  output apb_state_e       fsm_state
);

  // Upstream handshake: an access phase (PSEL & PENABLE) is accepted only in
  // IDLE; APBS_PREADY pulses for one cycle in RESP and the master ends the
  // transfer on it. Downstream follows SETUP then ACCESS until the selected
  // port raises PREADY or the watchdog expires.

  localparam int SW = sel_width(NS);
  localparam int CW = (clog2(TIMEOUT + 1) < 1) ? 1 : clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

  apb_state_e    state, state_n;
  logic [SW-1:0] sel_field;
  logic [SW-1:0] idx_q;
  logic [CW-1:0] cnt;
  logic          in_range;
  logic [DW-1:0] port_prdata;
  logic          port_pready;
  logic          port_pslverr;
  logic [DW-1:0] resp_data_n;
  logic          resp_err_n;
  logic          tout_n;

  assign sel_field = APBS_PADDR[SEL_LSB +: SW];
  assign fsm_state = state;

  apb_port_decode #(
    .DW(DW),
    .NS(NS),
    .SW(SW)
  ) u_decode (
    .sel_field  (sel_field),
    .in_range   (in_range),
    .port_idx   (idx_q),
    .prdata_all (APBM_PRDATA),
    .pready_all (APBM_PREADY),
    .pslverr_all(APBM_PSLVERR),
    .prdata     (port_prdata),
    .pready     (port_pready),
    .pslverr    (port_pslverr)
  );

  always_comb begin
    state_n     = state;
    resp_data_n = '0;
    resp_err_n  = 1'b0;
    tout_n      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (APBS_PSEL && APBS_PENABLE) begin
          if (in_range) begin
            state_n = ST_SETUP;
          end else begin
            state_n    = ST_RESP;
            resp_err_n = 1'b1;
          end
        end
      end
      ST_SETUP: state_n = ST_ACCESS;
      ST_ACCESS: begin
        // A ready on the final watchdog cycle still completes normally.
        if (port_pready) begin
          state_n     = ST_RESP;
          resp_err_n  = port_pslverr;
          resp_data_n = (APBM_PWRITE || port_pslverr) ? '0 : port_prdata;
        end else if ((TIMEOUT != 0) && (cnt == CNT_LAST)) begin
          state_n    = ST_RESP;
          resp_err_n = 1'b1;
          tout_n     = 1'b1;
        end
      end
      ST_RESP: state_n = ST_IDLE;
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge APB_CLK) begin
    if (APB_RESET) begin
      state        <= ST_IDLE;
      idx_q        <= '0;
      cnt          <= '0;
      APBS_PRDATA  <= '0;
      APBS_PREADY  <= 1'b0;
      APBS_PSLVERR <= 1'b0;
      APBM_PSEL    <= '0;
      APBM_PENABLE <= 1'b0;
      APBM_PWRITE  <= 1'b0;
      APBM_PADDR   <= '0;
      APBM_PWDATA  <= '0;
      APB_TOUT     <= 1'b0;
    end else begin
      state        <= state_n;
      APBS_PREADY  <= (state_n == ST_RESP);
      APBS_PRDATA  <= resp_data_n;
      APBS_PSLVERR <= resp_err_n;
      APB_TOUT     <= tout_n;
      APBM_PENABLE <= (state_n == ST_ACCESS);
      if (state == ST_ACCESS) begin
        cnt <= cnt + 1'b1;
      end
      // Downstream capture only for decodable addresses; errors leave it untouched.
      if (state_n == ST_SETUP) begin
        idx_q       <= sel_field;
        cnt         <= '0;
        APBM_PSEL   <= NS'(1) << sel_field;
        APBM_PADDR  <= APBS_PADDR;
        APBM_PWDATA <= APBS_PWDATA;
        APBM_PWRITE <= APBS_PWRITE;
      end else if (state_n != ST_ACCESS) begin
        APBM_PSEL <= '0;
      end
    end
  end

endmodule

// File: tb/tb_apb_fanout_slice.sv
// Self-checking bench for apb_fanout_slice: directed and random transfers,
// a scoreboard fed by the driver and a monitor that checks each response.
module tb_apb_fanout_slice;

  localparam int DW    = 16;
  localparam int AW    = 16;
  localparam int NS    = 3;
  // Watchdog length chosen so a 5-wait read lands exactly on its last cycle.
  localparam int T_OUT = 6;
  localparam int EW    = 34;
  localparam int DSW   = NS + AW + DW + 1;

  logic             APB_CLK = 1'b0;
  logic             APB_RESET = 1'b1;
  logic             APBS_PSEL, APBS_PENABLE, APBS_PWRITE;
  logic [AW-1:0]    APBS_PADDR;
  logic [DW-1:0]    APBS_PWDATA;
  logic [DW-1:0]    APBS_PRDATA;
  logic             APBS_PREADY, APBS_PSLVERR;
  logic [NS-1:0]    APBM_PSEL;
  logic             APBM_PENABLE, APBM_PWRITE;
  logic [AW-1:0]    APBM_PADDR;
  logic [DW-1:0]    APBM_PWDATA;
  logic [NS*DW-1:0] APBM_PRDATA;
  logic [NS-1:0]    APBM_PREADY, APBM_PSLVERR;
  logic             APB_TOUT;
  logic [1:0]       fsm_state;

  int tests = 0;
  int errors = 0;
  logic [EW-1:0]  exp_q[$];
  logic [DSW-1:0] ds_q[$];

  int            waits[NS];
  bit            hang[NS];
  logic [DW-1:0] rdat[NS];
  bit            serr[NS];
  int            acc_cnt[NS];

  apb_fanout_slice #(
    .DW(DW), .AW(AW), .NS(NS), .SEL_LSB(12), .TIMEOUT(T_OUT)
  ) dut (
    .APB_CLK(APB_CLK), .APB_RESET(APB_RESET),
    .APBS_PSEL(APBS_PSEL), .APBS_PENABLE(APBS_PENABLE), .APBS_PWRITE(APBS_PWRITE),
    .APBS_PADDR(APBS_PADDR), .APBS_PWDATA(APBS_PWDATA), .APBS_PRDATA(APBS_PRDATA),
    .APBS_PREADY(APBS_PREADY), .APBS_PSLVERR(APBS_PSLVERR),
    .APBM_PSEL(APBM_PSEL), .APBM_PENABLE(APBM_PENABLE), .APBM_PWRITE(APBM_PWRITE),
    .APBM_PADDR(APBM_PADDR), .APBM_PWDATA(APBM_PWDATA), .APBM_PRDATA(APBM_PRDATA),
    .APBM_PREADY(APBM_PREADY), .APBM_PSLVERR(APBM_PSLVERR),
    .APB_TOUT(APB_TOUT), .fsm_state(fsm_state)
  );

  // ---------------- clock / reset ----------------
  always #5 APB_CLK = ~APB_CLK;

  initial begin
    #800000;
    $display("FAIL global_timeout: simulation did not finish in time");
    $fatal(1, "global timeout");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] all_outputs();
    return 64'({APBS_PRDATA, APBS_PREADY, APBS_PSLVERR, APBM_PSEL, APBM_PENABLE,
                APBM_PADDR, APBM_PWDATA, APBM_PWRITE, APB_TOUT, fsm_state});
  endfunction

  // ---------------- downstream peripheral model ----------------
  initial begin
    APBM_PRDATA  = '0;
    APBM_PREADY  = '0;
    APBM_PSLVERR = '0;
    for (int i = 0; i < NS; i++) acc_cnt[i] = 0;
    forever begin
      @(negedge APB_CLK);
      for (int i = 0; i < NS; i++) begin
        if (APBM_PSEL[i] && APBM_PENABLE) begin
          APBM_PREADY[i]           = !hang[i] && (acc_cnt[i] == waits[i]);
          APBM_PRDATA[i*DW +: DW]  = rdat[i];
          APBM_PSLVERR[i]          = serr[i];
          acc_cnt[i]++;
        end else begin
          // Unselected ports present noise so a wrong mux choice shows up.
          APBM_PREADY[i]          = 1'($urandom_range(0, 1));
          APBM_PRDATA[i*DW +: DW] = DW'($urandom);
          APBM_PSLVERR[i]         = 1'($urandom_range(0, 1));
          acc_cnt[i]              = 0;
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cfg(input int port, input int w, input bit h, input logic [DW-1:0] d, input bit e);
    waits[port] = w;
    hang[port]  = h;
    rdat[port]  = d;
    serr[port]  = e;
  endtask

  // Reference model: response from the addressed port's behaviour and the watchdog rule.
  task automatic xfer(input logic [AW-1:0] addr, input logic [DW-1:0] wdata, input bit wr);
    int            port;
    logic [DW-1:0] d;
    bit            e, t, done;
    int            en, lat;
    logic [NS-1:0] oh;
    port = int'(addr[13:12]);
    if (port >= NS) begin
      d = '0; e = 1'b1; t = 1'b0; en = 0; lat = 1;
    end else begin
      if (hang[port] || waits[port] >= T_OUT) begin
        d = '0; e = 1'b1; t = 1'b1; en = T_OUT; lat = T_OUT + 2;
      end else begin
        e = serr[port];
        d = (wr || e) ? '0 : rdat[port];
        t = 1'b0; en = waits[port] + 1; lat = waits[port] + 3;
      end
      oh = '0;
      oh[port] = 1'b1;
      ds_q.push_back({oh, addr, wdata, wr});
    end
    exp_q.push_back({d, e, t, 8'(en), 8'(lat)});

    APBS_PADDR = addr; APBS_PWDATA = wdata; APBS_PWRITE = wr;
    APBS_PSEL = 1'b1; APBS_PENABLE = 1'b0;
    @(posedge APB_CLK); #1 APBS_PENABLE = 1'b1;
    @(posedge APB_CLK); #1;
    // Upstream fields change after capture; the bridge must ignore them.
    APBS_PADDR  = AW'($urandom);
    APBS_PWDATA = DW'($urandom);
    APBS_PWRITE = 1'($urandom_range(0, 1));
    done = 1'b0;
    for (int k = 0; k < 40 && !done; k++) begin
      @(negedge APB_CLK);
      if (APBS_PREADY) done = 1'b1;
    end
    if (!done) begin
      tests++;
      errors++;
      $display("FAIL xfer_wait: no PREADY for addr 0x%0h within 40 cycles", addr);
    end
    @(posedge APB_CLK); #1 APBS_PSEL = 1'b0; APBS_PENABLE = 1'b0;
  endtask

  task automatic reset_mid();
    logic [NS-1:0] oh;
    cfg(0, 10, 1'b0, 16'h5555, 1'b0);
    oh = '0;
    oh[0] = 1'b1;
    ds_q.push_back({oh, 16'h0040, 16'h7777, 1'b1});
    APBS_PADDR = 16'h0040; APBS_PWDATA = 16'h7777; APBS_PWRITE = 1'b1;
    APBS_PSEL = 1'b1; APBS_PENABLE = 1'b0;
    @(posedge APB_CLK); #1 APBS_PENABLE = 1'b1;
    repeat (3) @(posedge APB_CLK);
    #1 APB_RESET = 1'b1;
    @(posedge APB_CLK); #1 APB_RESET = 1'b0; APBS_PSEL = 1'b0; APBS_PENABLE = 1'b0;
    @(negedge APB_CLK);
    check("reset_mid_outputs", all_outputs(), 64'h0);
    repeat (10) @(negedge APB_CLK);
  endtask

  // ---------------- scoreboard monitor ----------------
  initial begin
    int            cyc, t0, en_cnt;
    bit            in_acc;
    logic [EW-1:0] e;
    cyc = 0; t0 = 0; en_cnt = 0; in_acc = 1'b0;
    forever begin
      @(negedge APB_CLK);
      cyc++;
      if (APB_RESET) begin
        in_acc = 1'b0;
        en_cnt = 0;
      end else begin
        if (APBS_PSEL && APBS_PENABLE && !in_acc) begin
          in_acc = 1'b1;
          t0 = cyc;
          en_cnt = 0;
        end
        if (APBM_PENABLE) en_cnt++;
        if (APBS_PREADY) begin
          if (exp_q.size() == 0) begin
            tests++;
            errors++;
            $display("FAIL unexpected_pready: PREADY with no transfer outstanding at %0t", $time);
          end else begin
            e = exp_q.pop_front();
            check("resp_prdata", 64'(APBS_PRDATA), 64'(e[33:18]));
            check("resp_pslverr", 64'(APBS_PSLVERR), 64'(e[17]));
            check("resp_tout", 64'(APB_TOUT), 64'(e[16]));
            check("penable_cycles", 64'(en_cnt), 64'(e[15:8]));
            check("resp_latency", 64'(cyc - t0), 64'(e[7:0]));
          end
          in_acc = 1'b0;
        end else begin
          check("prdata_idle_zero", 64'(APBS_PRDATA), 64'h0);
          check("tout_idle_zero", 64'(APB_TOUT), 64'h0);
        end
      end
    end
  end

  initial begin
    logic [DSW-1:0] d;
    forever begin
      @(negedge APB_CLK);
      if (!APB_RESET) begin
        check("psel_onehot", 64'($countones(APBM_PSEL) <= 1), 64'h1);
        if (APBM_PSEL != '0 && !APBM_PENABLE) begin
          if (ds_q.size() == 0) begin
            tests++;
            errors++;
            $display("FAIL unexpected_setup: downstream PSEL 0x%0h with none expected", APBM_PSEL);
          end else begin
            d = ds_q.pop_front();
            check("downstream_setup", 64'({APBM_PSEL, APBM_PADDR, APBM_PWDATA, APBM_PWRITE}), 64'(d));
          end
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [AW-1:0] addr;
    int            port;
    APBS_PSEL = 1'b0; APBS_PENABLE = 1'b0; APBS_PWRITE = 1'b0;
    APBS_PADDR = '0; APBS_PWDATA = '0;
    for (int i = 0; i < NS; i++) cfg(i, 0, 1'b0, '0, 1'b0);
    repeat (3) @(posedge APB_CLK);
    @(negedge APB_CLK);
    check("reset_outputs", all_outputs(), 64'h0);
    @(posedge APB_CLK); #1 APB_RESET = 1'b0;

    cfg(2, 0, 1'b0, 16'h0000, 1'b0);
    xfer(16'h2010, 16'hA5A5, 1'b1);
    cfg(1, 5, 1'b0, 16'h1234, 1'b0);
    xfer(16'h1000, 16'h0000, 1'b0);
    xfer(16'h3000, 16'hFFFF, 1'b1);
    cfg(0, 0, 1'b1, 16'hDEAD, 1'b0);
    xfer(16'h0004, 16'h0001, 1'b0);
    cfg(0, T_OUT, 1'b0, 16'hCAFE, 1'b0);
    xfer(16'h0008, 16'h0002, 1'b0);
    cfg(0, T_OUT - 1, 1'b0, 16'hBEEF, 1'b0);
    xfer(16'h000C, 16'h0003, 1'b0);
    cfg(1, 2, 1'b0, 16'h4321, 1'b1);
    xfer(16'h1FF0, 16'h0004, 1'b0);

    reset_mid();
    cfg(0, 1, 1'b0, 16'h0F0F, 1'b0);
    xfer(16'h0100, 16'h0000, 1'b0);

    cfg(2, 1, 1'b0, 16'h1111, 1'b0);
    cfg(0, 2, 1'b0, 16'h2222, 1'b0);
    xfer(16'h2222, 16'h5A5A, 1'b1);
    xfer(16'h0333, 16'h0000, 1'b0);

    for (int n = 0; n < 60; n++) begin
      port = $urandom_range(0, 3);
      addr = AW'($urandom);
      addr[13:12] = 2'(port);
      if (port < NS) begin
        cfg(port, $urandom_range(0, 8), ($urandom_range(0, 9) == 0),
            DW'($urandom), ($urandom_range(0, 4) == 0));
      end
      xfer(addr, DW'($urandom), 1'($urandom_range(0, 1)));
    end

    repeat (5) @(negedge APB_CLK);
    check("exp_q_drained", 64'(exp_q.size()), 64'h0);
    check("ds_q_drained", 64'(ds_q.size()), 64'h0);
    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
